// File: rtl/riscv_defines.sv
// Shared definitions for the branch prediction unit: counter encoding,
// default geometry and the BTB entry layout.
package riscv_defines;

    localparam int unsigned XLEN_DEFAULT      = 32;
    localparam int unsigned BTB_IDX_W_DEFAULT = 4;
    // Tag keeps every PC bit above the index and the 2-bit word offset.
    localparam int unsigned BP_TAG_W          = XLEN_DEFAULT - BTB_IDX_W_DEFAULT - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_counter_t;

    // Entry geometry follows the package defaults; XLEN/BTB_IDX_W overrides
    // on the modules must match them.
    typedef struct packed {
        logic                    valid;
        logic [BP_TAG_W-1:0]     tag;
        logic [XLEN_DEFAULT-1:0] target;
        bp_counter_t             counter;
    } bp_entry_t;

    // One step of the 2-bit saturating counter toward the resolved direction.
    function automatic bp_counter_t bp_sat_update(input bp_counter_t cnt, input logic taken);
        bp_counter_t nxt;
        nxt = cnt;
        case (cnt)
            SNT: nxt = taken ? WNT : SNT;
            WNT: nxt = taken ? WT  : SNT;
            WT:  nxt = taken ? ST  : WNT;
            ST:  nxt = taken ? ST  : WT;
            default: nxt = WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: asynchronous read port for fetch,
// synchronous update port for resolved control-flow instructions in E.
// Reads during a same-index write return the pre-write contents.
module branch_target_buffer
    import riscv_defines::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [BTB_IDX_W-1:0]        rd_idx,
    input  logic [XLEN-BTB_IDX_W-3:0]   rd_tag,
    output logic                        rd_taken,
    output logic [XLEN-1:0]             rd_target,
    input  logic                        upd_en,
    input  logic                        upd_jump,
    input  logic                        upd_taken,
    input  logic [BTB_IDX_W-1:0]        upd_idx,
    input  logic [XLEN-BTB_IDX_W-3:0]   upd_tag,
    input  logic [XLEN-1:0]             upd_target
);

    localparam int unsigned ENTRIES = 1 << BTB_IDX_W;

    bp_entry_t entries [ENTRIES];
    bp_entry_t rd_entry;
    bp_entry_t upd_cur;
    bp_entry_t upd_nxt;
    logic      rd_hit;
    logic      upd_match;

    // Fetch-side lookup: predict taken only on a tag hit with counter MSB set.
    always_comb begin
        rd_entry  = entries[rd_idx];
        rd_hit    = rd_entry.valid && (rd_entry.tag == rd_tag);
        rd_taken  = rd_hit && rd_entry.counter[1];
        rd_target = rd_taken ? rd_entry.target : '0;
    end

    // Next contents of the entry addressed by the E-stage instruction.
    always_comb begin
        upd_cur   = entries[upd_idx];
        upd_nxt   = upd_cur;
        // An invalid entry trains like a hit so a cold branch starts from WNT.
        upd_match = !upd_cur.valid || (upd_cur.tag == upd_tag);
        if (upd_match) begin
            if (upd_jump) begin
                upd_nxt.counter = ST;
            end else begin
                upd_nxt.counter = bp_sat_update(upd_cur.counter, upd_taken);
            end
        end else begin
            upd_nxt.counter = upd_taken ? WT : WNT;
        end
        if (upd_taken) begin
            upd_nxt.valid  = 1'b1;
            upd_nxt.tag    = upd_tag;
            upd_nxt.target = upd_target;
        end
    end

    // Entry array: cleared to invalid/WNT on reset, written on resolved control flow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                entries[i] <= '{valid: 1'b0, tag: '0, target: '0, counter: WNT};
            end
        end else if (upd_en) begin
            entries[upd_idx] <= upd_nxt;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor and mispredict detector for the 5-stage core.
// Define BRANCH_PREDICT_EN to build the BTB and the F->D->E prediction
// pipeline; without it the core predicts not-taken for every fetch and
// every taken control-flow instruction in E is a mispredict.
module branch_predict_unit
    import riscv_defines::*;
#(
    parameter int unsigned XLEN      = XLEN_DEFAULT,
    parameter int unsigned BTB_IDX_W = BTB_IDX_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            flush_e,
    input  logic            valid_e,
    input  logic            branch_e,
    input  logic            jump_e,
    input  logic            taken_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] target_e,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc
);

    logic            ctl_e;
    logic [XLEN-1:0] seq_pc_e;

    assign ctl_e    = valid_e && (branch_e || jump_e);
    assign seq_pc_e = pc_e + XLEN'(4);

    // Correct next PC; falls back to the sequential PC while in reset.
    always_comb begin
        redirect_pc = seq_pc_e;
        if (rst_n && taken_e) begin
            redirect_pc = target_e;
        end
    end

`ifdef BRANCH_PREDICT_EN

    logic            btb_taken;
    logic [XLEN-1:0] btb_target;
    logic            pred_taken_d;
    logic [XLEN-1:0] pred_target_d;
    logic            pred_taken_e;
    logic [XLEN-1:0] pred_target_e;

    branch_target_buffer #(
        .XLEN      (XLEN),
        .BTB_IDX_W (BTB_IDX_W)
    ) u_btb (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_idx     (pc_f[BTB_IDX_W+1:2]),
        .rd_tag     (pc_f[XLEN-1:BTB_IDX_W+2]),
        .rd_taken   (btb_taken),
        .rd_target  (btb_target),
        .upd_en     (ctl_e),
        .upd_jump   (jump_e),
        .upd_taken  (taken_e),
        .upd_idx    (pc_e[BTB_IDX_W+1:2]),
        .upd_tag    (pc_e[XLEN-1:BTB_IDX_W+2]),
        .upd_target (target_e)
    );

    assign pred_taken_f  = btb_taken;
    assign pred_target_f = btb_target;

    // F->D prediction register: flush beats stall, stall holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
        end else if (flush_d) begin
            pred_taken_d  <= 1'b0;
            pred_target_d <= '0;
        end else if (!stall_d) begin
            pred_taken_d  <= pred_taken_f;
            pred_target_d <= pred_target_f;
        end
    end

    // D->E prediction register: cleared by flush_e, otherwise follows D.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_e  <= 1'b0;
            pred_target_e <= '0;
        end else if (flush_e) begin
            pred_taken_e  <= 1'b0;
            pred_target_e <= '0;
        end else begin
            pred_taken_e  <= pred_taken_d;
            pred_target_e <= pred_target_d;
        end
    end

    // Wrong direction, wrong taken target, or a taken alias on a non-control instruction.
    always_comb begin
        mispredict = 1'b0;
        if (rst_n) begin
            mispredict = (ctl_e && (pred_taken_e != taken_e))
                      || (ctl_e && taken_e && (pred_target_e != target_e))
                      || (valid_e && !ctl_e && pred_taken_e);
        end
    end

`else

    assign pred_taken_f  = 1'b0;
    assign pred_target_f = '0;

    // Static not-taken: any taken control-flow instruction redirects.
    always_comb begin
        mispredict = 1'b0;
        if (rst_n) begin
            mispredict = ctl_e && taken_e;
        end
    end

`endif

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Dynamic branch predictor and mispredict detector for the 5-stage core. A direct-mapped BTB with 2-bit saturating counters predicts next-fetch direction and target in F. The block carries each prediction alongside the instruction to E, compares it with the resolved outcome, and raises `mispredict` plus a redirect PC. `mispredict` feeds the hazard unit's flush logic directly.

## Interface
- `XLEN`, 32, address width
- `BTB_IDX_W`, 4, index bits; entries = 2**BTB_IDX_W

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `pc_f`  in  XLEN  fetch PC
- `pred_taken_f`  out  1  predicted taken for `pc_f`
- `pred_target_f`  out  XLEN  predicted target (0 when not taken)
- `stall_d`  in  1  hold the F→D prediction register
- `flush_d`  in  1  clear the F→D prediction register
- `flush_e`  in  1  clear the D→E prediction register
- `valid_e`  in  1  E holds a real instruction
- `branch_e`  in  1  conditional branch in E
- `jump_e`  in  1  JAL/JALR in E
- `taken_e`  in  1  resolved direction (1 for jumps)
- `pc_e`  in  XLEN  PC of the E instruction
- `target_e`  in  XLEN  resolved target
- `mispredict`  out  1  prediction wrong; combinational from E state
- `redirect_pc`  out  XLEN  correct next PC when `mispredict`=1

## Operation
- **Index and tag:** index = `pc[BTB_IDX_W+1:2]`; tag = `pc[XLEN-1:BTB_IDX_W+2]`.
- **Per-entry state:** valid bit, tag, target, 2-bit counter.
- **Counter encoding:** SNT=00, WNT=01, WT=10, ST=11.
- **Prediction (F):** hit = valid && tag match. `pred_taken_f` = hit && counter[1]. `pred_target_f` = entry target when `pred_taken_f`=1, else 0.
- **F→D register (pred_taken, pred_target):**
  - `flush_d` clears it.
  - Otherwise `stall_d` holds it.
  - Otherwise it loads the F values.
  - Flush has priority over stall.
- **D→E register:** `flush_e` clears it; otherwise it loads from D every cycle.
- **Mispredict, with `ctl` = `valid_e` && (`branch_e` || `jump_e`):**
  - Case 1: `ctl` && (`pred_taken_e` != `taken_e`).
  - Case 2: `ctl` && `taken_e` && `pred_target_e` != `target_e`.
  - Case 3: `valid_e` && !`ctl` && `pred_taken_e` (an alias predicted taken on a non-control instruction).
- **Redirect:** `redirect_pc` = `taken_e` ? `target_e` : `pc_e`+4, wrapping mod 2**XLEN.
- **Update, when `ctl`=1, at the entry indexed by `pc_e`:**
  - Tag match or invalid entry:
    - Conditional branch: counter saturates ±1 toward `taken_e` (no wrap past 00/11).
    - Jump: counter set to ST.
  - Tag miss on a valid entry: counter set to WT if taken, WNT if not.
  - If `taken_e`: write tag, target and valid=1.
  - If not taken and the tag misses: entry left unchanged except for the counter rule above.
- **No update when `ctl`=0.**

## Timing
- Prediction is combinational, pc_f → outputs, with zero latency.
- Table updates commit at the `clk` rising edge and are visible to `pc_f` the next cycle.
- Same-index read and write in one cycle: the read returns the old contents (no bypass).
- `mispredict` and `redirect_pc` are combinational in the same cycle the instruction sits in E. The hazard unit flushes D/E on the following edge.
- **Reset** (async assert, sync-release expected upstream):
  - All valid bits cleared, all counters set to WNT.
  - Pipeline prediction registers cleared to 0.
  - Outputs go to 0 immediately: `pred_taken_f`, `pred_target_f`, `mispredict`; `redirect_pc`=`pc_e`+4.
- Reset mid-update: the write is discarded.

## Configuration
- Macro: `BRANCH_PREDICT_EN`.
- **Defined:** full behaviour as above.
- **Undefined:**
  - No tables are built.
  - `pred_taken_f`=0 and `pred_target_f`=0 constantly.
  - Pipeline registers are optimised away.
  - `mispredict` = `valid_e` && (`branch_e` || `jump_e`) && `taken_e`; `redirect_pc` as above.

## Structure
- **Package `riscv_defines`:**
  - `bp_counter_t` enum (SNT/WNT/WT/ST).
  - `BTB_IDX_W_DEFAULT`.
  - `bp_entry_t` struct (valid, tag, target, counter).
- **Sub-module `branch_target_buffer`:** holds the entry array, the async read port and the sync write/update port (counter logic included).
- **Top level:** F→D and D→E registers plus mispredict/redirect logic.

## Test plan
- **Cold reset:** `pc_f`=0x100 → `pred_taken_f`=0. Taken branch at E (`pc_e`=0x100, `target_e`=0x80) → `mispredict`=1, `redirect_pc`=0x80.
- **Learn:** same branch taken again; the next fetch of 0x100 → `pred_taken_f`=1, `pred_target_f`=0x80. With the branch taken again in E → `mispredict`=0.
- **Saturation:** branch at 0x200 taken 3 times, then not-taken 1 time → still predicted taken (counter ST→WT).
  - On that not-taken resolve, `mispredict`=1 with `redirect_pc`=0x204.
  - One further not-taken → predicts not-taken.
- **Alias:** entry at 0x100 trained; `pc_f`=0x100+(1<<6) → no hit.
  - Force a predicted-taken non-control instruction into E → `mispredict`=1, `redirect_pc`=`pc_e`+4.
- **Stall/flush priority:** `stall_d`=1 and `flush_d`=1 in the same cycle → D prediction cleared. A later `flush_e` → no mispredict for the bubble (`valid_e`=0).
- **Wrong target:** JALR trained to 0x400 resolves to 0x500 → `mispredict`=1, `redirect_pc`=0x500, BTB target updated to 0x500.
